button_event_queue: RTL
=======================

// Module: button_event_queue
// PURPOSE
//  - Consumer of the per-button rising-edge pulses from the button synchronizer stage.
//  - Per-button lockout window removes contact bounce. Accepted presses are serialized
//    (lowest index first) into a small FIFO.
//  - Presents one button-ID event at a time to the control FSM over a valid/ready handshake.
// PARAMETERS
//  - P_BUTTON_WIDTH    5          number of buttons (>=2)
//  - P_LOCKOUT_CYCLES  1000000    cycles an edge on a button is ignored after an accept (0 = no lockout)
//  - P_FIFO_DEPTH      8          event FIFO entries, power of 2, >=2
// PORTS
//  - iClk         in   1                        system clock
//  - iRst         in   1                        synchronous, active-high reset
//  - iButtonEdge  in   P_BUTTON_WIDTH           1-cycle rising-edge pulses, already synchronized to iClk
//  - oEvtValid    out  1                        head event available
//  - iEvtReady    in   1                        consumer accepts head when oEvtValid & iEvtReady
//  - oEvtId       out  clog2(P_BUTTON_WIDTH)    button index of head event
//  - oEvtCount    out  clog2(P_FIFO_DEPTH)+1    FIFO occupancy
//  - oOverflow    out  1                        sticky: an accepted press was merged/lost
// BEHAVIOUR
//  - Reset (sync, every iClk edge with iRst=1) clears all state.
//    Reset values: oEvtValid=0, oEvtId=0, oEvtCount=0, oOverflow=0.
//    Lockout counters, pending bits and FIFO pointers are also cleared.
//    Any in-flight events are discarded.
//  - Lockout, per button i:
//    - edge accepted only when lockCnt[i]==0;
//    - an accept loads lockCnt[i] with P_LOCKOUT_CYCLES; the counter decrements by 1 per cycle
//      to 0 and holds there;
//    - accept at cycle t -> edges at t+1..t+P_LOCKOUT_CYCLES ignored, t+P_LOCKOUT_CYCLES+1 accepted.
//  - Pending: an accept sets rPend[i] at the next edge.
//    Accept while rPend[i] already set -> event merged, oOverflow<=1.
//    oOverflow is cleared only by reset.
//  - Push:
//    - each cycle the lowest set rPend bit is written to the FIFO and cleared;
//    - allowed if count<P_FIFO_DEPTH, or the FIFO is full and a pop occurs in the same cycle;
//    - otherwise rPend holds; nothing is dropped.
//  - Pop: oEvtValid & iEvtReady advances the head. Push+pop in the same cycle leaves the count unchanged.
//  - FIFO is show-ahead: oEvtValid = (count!=0); oEvtId = entry[rdPtr].
//  - Latency: edge in cycle N with FIFO empty and no other pending -> oEvtValid=1 and oEvtId valid in cycle N+2.
//  - Throughput: 1 push and 1 pop per cycle max. Simultaneous edges are emitted in ascending index order.
//  - Pointers wrap modulo P_FIFO_DEPTH. A pop when empty or a push when full (no pop) has no effect.
//  - iEvtReady while oEvtValid=0 is ignored. oEvtId holds stable while oEvtValid & !iEvtReady.
// CONFIGURATION
//  - Macro BUTTON_EVT_DROP_CNT_EN.
//  - Defined: adds port oDropCnt out 8, which counts merged events.
//    oDropCnt resets to 0, increments on every merge, saturates at 255.
//    If several merges occur in one cycle, it adds their number, saturating.
//  - Undefined: port and counter are absent; only the sticky oOverflow remains.
// STRUCTURE
//  - Shared header button_defs.vh: clog2 function, default lockout/depth localparams,
//    and event-ID width derivation. The same header is used by the synchronizer and the control FSM.
//  - Sub-module button_evt_fifo: generic sync show-ahead FIFO
//    (params P_DATA_WIDTH, P_DEPTH; ports iWrEn/iWrData/iRdEn/oRdData/oEmpty/oFull/oCount).
//  - Lockout counters, pending register and priority encoder stay in the top module.
// TESTING  (bench: P_BUTTON_WIDTH=5, P_LOCKOUT_CYCLES=4, P_FIFO_DEPTH=4)
//  - Reset, then single event: after reset all outputs are 0.
//    Edge bit2 at cycle 10, iEvtReady=1 -> oEvtValid=1 and oEvtId=2 in cycle 12.
//    oEvtValid=0 in cycle 13.
//  - Bounce: bit0 edges at cycles 10, 12 and 14 -> exactly one event, id 0.
//    Further edge at cycle 15 -> second event, id 0, valid in cycle 17.
//  - Simultaneous edges: iButtonEdge=5'b11010 at cycle 10, iEvtReady=1 -> ids 1, 3, 4 valid in cycles 12, 13, 14.
//    oOverflow stays 0.
//  - Backpressure: iEvtReady=0, single edges on bits 0..4 at cycles 10..14 -> oEvtCount=4 and one event held pending.
//    oOverflow=0. Raising ready -> ids 0,1,2,3,4 drained in order, count returns to 0.
//  - Overflow: iEvtReady=0, FIFO full, bit4 pending. Bit4 edge after lockout expires -> oOverflow=1.
//    oDropCnt=1 with BUTTON_EVT_DROP_CNT_EN. On drain, only one id-4 event remains.
//  - Reset mid-operation: iRst=1 for 1 cycle with oEvtCount=3 and lockouts active.
//    Next cycle oEvtValid=0, oEvtCount=0, oOverflow=0. An edge 1 cycle after reset is accepted immediately.

Source files
------------

// File: rtl/button_event_queue_pkg.sv
// -----------------------------------------------------------------------------
// button_event_queue_pkg
// Shared definitions for the button event path. Both button_event_queue and
// button_evt_fifo use them, and so can the synchronizer and the control FSM.
//   - clog2()        : ceiling log2 for sizing (clog2(1) = 0)
//   - evt_id_width() : width of a button index, never less than 1
//   - cnt_width()    : width needed to hold 0..max_value, never less than 1
//   - DEF_*          : default parameter values for the queue
// Configuration macro: BUTTON_EVT_DROP_CNT_EN (see button_event_queue).
// -----------------------------------------------------------------------------
package button_event_queue_pkg;

    localparam int DEF_BUTTON_WIDTH   = 5;
    localparam int DEF_LOCKOUT_CYCLES = 1000000;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DROP_CNT_W         = 8;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int evt_id_width(input int buttons);
        return (clog2(buttons) < 1) ? 1 : clog2(buttons);
    endfunction

    function automatic int cnt_width(input int max_value);
        return (clog2(max_value + 1) < 1) ? 1 : clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/button_evt_fifo.sv
// -----------------------------------------------------------------------------
// button_evt_fifo
// Generic synchronous show-ahead FIFO. The head entry is always visible on
// oRdData. A read advances the head on the next clock edge.
// Parameters: P_DATA_WIDTH (entry width), P_DEPTH (entries, power of 2, >=2).
// Ports:
//   iClk, iRst : clock, synchronous active-high reset
//   iWrEn      : write request; it takes effect when not full, or when full
//                and a read happens in the same cycle
//   iWrData    : data to write
//   iRdEn      : read request; it is ignored while empty
//   oRdData    : head entry (entry[rd_ptr])
//   oEmpty     : occupancy is zero
//   oFull      : occupancy equals P_DEPTH
//   oCount     : occupancy, 0..P_DEPTH
// Handshake: a write is accepted when iWrEn is high and the FIFO is not full,
// or when it is full and a read is accepted in the same cycle. A read is
// accepted when iRdEn is high and the FIFO is not empty. An accepted write and
// an accepted read in the same cycle leave oCount unchanged.
// -----------------------------------------------------------------------------
module button_evt_fifo
    import button_event_queue_pkg::*;
#(
    parameter int P_DATA_WIDTH = 3,
    parameter int P_DEPTH      = 8
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iWrEn,
    input  logic [P_DATA_WIDTH-1:0]   iWrData,
    input  logic                      iRdEn,
    output logic [P_DATA_WIDTH-1:0]   oRdData,
    output logic                      oEmpty,
    output logic                      oFull,
    output logic [clog2(P_DEPTH):0]   oCount
);

    localparam int PTR_W = clog2(P_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [P_DATA_WIDTH-1:0] mem [P_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic                    wr_ok;
    logic                    rd_ok;

    assign oEmpty  = (count == '0);
    assign oFull   = (count == CNT_W'(P_DEPTH));
    assign oCount  = count;
    assign oRdData = mem[rd_ptr];

    assign rd_ok = iRdEn && !oEmpty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign wr_ok = iWrEn && (!oFull || rd_ok);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // Cleared so that the head reads as 0 after reset.
            for (int i = 0; i < P_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= iWrData;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/button_event_queue.sv
// -----------------------------------------------------------------------------
// button_event_queue
// Takes per-button rising-edge pulses, which are already synchronized to iClk,
// and removes contact bounce with a per-button lockout window. Accepted presses
// are queued into a FIFO, lowest button index first, and presented to the
// consumer one button ID at a time.
// Parameters:
//   P_BUTTON_WIDTH   : number of buttons (>=2)
//   P_LOCKOUT_CYCLES : cycles during which edges are ignored after an accept
//                      (0 = no lockout)
//   P_FIFO_DEPTH     : event FIFO entries (power of 2, >=2)
// Ports:
//   iClk, iRst  : clock, synchronous active-high reset
//   iButtonEdge : one-cycle rising-edge pulses, one bit per button
//   oEvtValid   : a head event is available
//   iEvtReady   : consumer takes the head when oEvtValid & iEvtReady
//   oEvtId      : button index of the head event
//   oEvtCount   : FIFO occupancy
//   oOverflow   : sticky; an accepted press was merged into a pending one
//   oDropCnt    : (only with BUTTON_EVT_DROP_CNT_EN) saturating count of
//                 merged presses
// Handshake: oEvtValid/oEvtId are registered FIFO outputs. The head is consumed
// on a clock edge where oEvtValid and iEvtReady are both high. iEvtReady has no
// effect while oEvtValid is low. oEvtId is stable while oEvtValid is high and
// iEvtReady is low.
// -----------------------------------------------------------------------------
module button_event_queue
    import button_event_queue_pkg::*;
#(
    parameter int P_BUTTON_WIDTH   = DEF_BUTTON_WIDTH,
    parameter int P_LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int P_FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
    input  logic                                    iClk,
    input  logic                                    iRst,
    input  logic [P_BUTTON_WIDTH-1:0]               iButtonEdge,
    output logic                                    oEvtValid,
    input  logic                                    iEvtReady,
    output logic [evt_id_width(P_BUTTON_WIDTH)-1:0] oEvtId,
    output logic [clog2(P_FIFO_DEPTH):0]            oEvtCount,
    output logic                                    oOverflow
`ifdef BUTTON_EVT_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]                   oDropCnt
`endif
);

    localparam int                ID_W      = evt_id_width(P_BUTTON_WIDTH);
    localparam int                LOCK_W    = cnt_width(P_LOCKOUT_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(P_LOCKOUT_CYCLES);

    logic [LOCK_W-1:0]         lock_cnt [P_BUTTON_WIDTH];
    logic [P_BUTTON_WIDTH-1:0] accept;
    logic [P_BUTTON_WIDTH-1:0] pend;
    logic [P_BUTTON_WIDTH-1:0] push_onehot;
    logic [P_BUTTON_WIDTH-1:0] push_clear;
    logic [P_BUTTON_WIDTH-1:0] merge;
    logic [ID_W-1:0]           push_id;
    logic                      push_en;
    logic                      pop_en;
    logic                      fifo_empty;
    logic                      fifo_full;

    // An edge is accepted only while its button's lockout counter is idle.
    always_comb begin
        accept = '0;
        for (int i = 0; i < P_BUTTON_WIDTH; i++) begin
            accept[i] = iButtonEdge[i] && (lock_cnt[i] == '0);
        end
    end

    // The counter loads on an accept and counts down to 0. With a load of L,
    // the next L cycles are masked.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < P_BUTTON_WIDTH; i++) begin
                lock_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < P_BUTTON_WIDTH; i++) begin
                if (accept[i]) begin
                    lock_cnt[i] <= LOCK_LOAD;
                end else if (lock_cnt[i] != '0) begin
                    lock_cnt[i] <= lock_cnt[i] - LOCK_W'(1);
                end
            end
        end
    end

    // Priority encoder: the scan runs downward, so the lowest set bit is
    // written last and wins.
    always_comb begin
        push_onehot = '0;
        push_id     = '0;
        for (int i = P_BUTTON_WIDTH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                push_onehot    = '0;
                push_onehot[i] = 1'b1;
                push_id        = ID_W'(i);
            end
        end
    end

    assign oEvtValid  = !fifo_empty;
    assign pop_en     = oEvtValid && iEvtReady;
    assign push_en    = (pend != '0) && (!fifo_full || pop_en);
    assign push_clear = push_en ? push_onehot : '0;
    // A new accept on a bit that is leaving pend this cycle is not a loss. It
    // simply becomes pending again.
    assign merge      = accept & pend & ~push_clear;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            pend      <= '0;
            oOverflow <= 1'b0;
        end else begin
            pend <= (pend & ~push_clear) | accept;
            if (merge != '0) begin
                oOverflow <= 1'b1;
            end
        end
    end

`ifdef BUTTON_EVT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_next;

    // Several merges in one cycle add their number, and the result saturates.
    always_comb begin
        int n;
        int total;
        n = 0;
        for (int i = 0; i < P_BUTTON_WIDTH; i++) begin
            n = n + int'(merge[i]);
        end
        total     = int'(oDropCnt) + n;
        drop_next = (total > 255) ? 8'hFF : DROP_CNT_W'(total);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oDropCnt <= '0;
        end else begin
            oDropCnt <= drop_next;
        end
    end
`endif

    button_evt_fifo #(
        .P_DATA_WIDTH (ID_W),
        .P_DEPTH      (P_FIFO_DEPTH)
    ) u_fifo (
        .iClk    (iClk),
        .iRst    (iRst),
        .iWrEn   (push_en),
        .iWrData (push_id),
        .iRdEn   (pop_en),
        .oRdData (oEvtId),
        .oEmpty  (fifo_empty),
        .oFull   (fifo_full),
        .oCount  (oEvtCount)
    );

endmodule
